chip8_key_input: RTL and testbench

- Consumes the 16-bit raw pressed-key vector produced by the keypad matrix scanner: bit n = 1 means hex key n is held.
- Debounces each key independently and exposes a stable key vector.
- Answers single-key queries for SKP/SKNP.
- Implements the FX0A "wait for key" handshake: reports a key only after it is pressed and then released.
- Sits between the keypad scanner and the CPU execute stage.

---
 rtl/chip8_key_input_pkg.sv | 30 +++
 rtl/chip8_key_input_debounce.sv | 38 +++
 rtl/chip8_key_input.sv | 109 ++++++++++
 tb/tb_chip8_key_input.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_key_input_pkg.sv
// Shared definitions for the CHIP-8 keypad input block.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//   NUM_KEYS     - number of hex keys on the pad
//   KEY_IDX_W    - width of a key index
//   wait_state_t - FX0A wait FSM encoding
//   lowest_set() - priority encoder, lowest set bit wins
package chip8_key_input_pkg;

  localparam int NUM_KEYS  = 16;
  localparam int KEY_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } wait_state_t;

  // Scan from the top down so the lowest set index is the last one written.
  function automatic logic [KEY_IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chip8_key_input_debounce.sv
// Single-bit debouncer: output follows input once it has disagreed for DEBOUNCE_CYCLES edges.
// Latency: DEBOUNCE_CYCLES clk edges from a stable change to the registered output.
// Backpressure: none; samples every cycle.
//   clk    - system clock
//   rst_n  - synchronous reset, active low
//   raw    - raw key bit from the scanner
//   stable - debounced key bit, registered
module key_debounce #(
  parameter  int DEBOUNCE_CYCLES = 64,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The counter tracks how many consecutive edges raw has disagreed with
  // stable; any agreeing sample throws the partial run away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= raw;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/chip8_key_input.sv
// Keypad front end: per-key debounce, SKP/SKNP query mux and FX0A wait-for-key handshake.
// Latency: keys DEBOUNCE_CYCLES after a stable change; wait_done one cycle after keys shows the release.
// Backpressure: none; wait_req is a level held by the CPU, wait_done is a single-cycle pulse.
//   clk, rst_n     - clock, synchronous active-low reset
//   raw_keys       - raw pressed-key vector from the scanner
//   keys, any_key  - debounced key vector and its OR
//   query_idx      - key index for SKP/SKNP; query_pressed = keys[query_idx]
//   wait_req       - FX0A in progress; wait_done/wait_key report the pressed-then-released key
module chip8_key_input
  import chip8_key_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_KEYS-1:0]  raw_keys,
  output logic [NUM_KEYS-1:0]  keys,
  output logic                 any_key,
  input  logic [KEY_IDX_W-1:0] query_idx,
  output logic                 query_pressed,
  input  logic                 wait_req,
  output logic                 wait_done,
  output logic [KEY_IDX_W-1:0] wait_key
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_keys[g]),
      .stable (keys[g])
    );
  end

  assign any_key       = |keys;
  assign query_pressed = keys[query_idx];

  wait_state_t          state, state_nxt;
  logic [NUM_KEYS-1:0]  held_mask, held_mask_nxt;
  logic [KEY_IDX_W-1:0] sel, sel_nxt;
  logic                 wait_done_nxt;
  logic [KEY_IDX_W-1:0] wait_key_nxt;
  logic [NUM_KEYS-1:0]  cand;

  // Only keys that went down after the wait was armed are candidates.
  assign cand = keys & ~held_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      held_mask <= '0;
      sel       <= '0;
      wait_done <= 1'b0;
      wait_key  <= '0;
    end else begin
      state     <= state_nxt;
      held_mask <= held_mask_nxt;
      sel       <= sel_nxt;
      wait_done <= wait_done_nxt;
      wait_key  <= wait_key_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    held_mask_nxt = held_mask;
    sel_nxt       = sel;
    wait_done_nxt = 1'b0;
    wait_key_nxt  = wait_key;

    unique case (state)
      IDLE: begin
        if (wait_req) begin
          state_nxt     = WAIT_PRESS;
          held_mask_nxt = keys;
        end
      end
      WAIT_PRESS: begin
        // Releasing a key that was down at arm time drops it from the mask,
        // so pressing it again counts as a fresh press.
        held_mask_nxt = held_mask & keys;
        if (!wait_req) begin
          state_nxt = IDLE;
        end else if (cand != '0) begin
          sel_nxt   = lowest_set(cand);
          state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        // An abort takes precedence over a release seen in the same cycle.
        if (!wait_req) begin
          state_nxt = IDLE;
        end else if (!keys[sel]) begin
          wait_done_nxt = 1'b1;
          wait_key_nxt  = sel;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        // Holding here until wait_req drops keeps one FX0A from reporting twice.
        if (!wait_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_key_input.sv
module tb_chip8_key_input;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] raw_keys;
  logic [15:0] keys;
  logic        any_key;
  logic [3:0]  query_idx;
  logic        query_pressed;
  logic        wait_req;
  logic        wait_done;
  logic [3:0]  wait_key;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chip8_key_input #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raw_keys      (raw_keys),
    .keys          (keys),
    .any_key       (any_key),
    .query_idx     (query_idx),
    .query_pressed (query_pressed),
    .wait_req      (wait_req),
    .wait_done     (wait_done),
    .wait_key      (wait_key)
  );

  // Reference model: per key, count consecutive disagreeing samples and adopt
  // the raw value once DEB of them have been seen; the wait handshake is
  // tracked as a phase number 0..3 (idle, press, release, done).
  logic [15:0] m_keys = '0;
  int          m_run[16];
  int          m_phase = 0;
  logic [15:0] m_held = '0;
  int          m_sel = 0;
  logic        m_done = 1'b0;
  int          m_wkey = 0;

  task automatic model_step();
    logic [15:0] k;
    logic [15:0] cand;
    bit          found;
    k = m_keys;
    if (!rst_n) begin
      m_keys = '0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
      m_phase = 0; m_held = '0; m_sel = 0; m_done = 1'b0; m_wkey = 0;
      return;
    end
    m_done = 1'b0;
    case (m_phase)
      0: if (wait_req) begin m_phase = 1; m_held = k; end
      1: begin
        cand   = k & ~m_held;
        m_held = m_held & k;
        if (!wait_req) m_phase = 0;
        else if (cand != 0) begin
          found = 0;
          for (int i = 0; i < 16; i++)
            if (!found && cand[i]) begin m_sel = i; found = 1; end
          m_phase = 2;
        end
      end
      2: if (!wait_req) m_phase = 0;
         else if (!k[m_sel]) begin m_done = 1'b1; m_wkey = m_sel; m_phase = 3; end
      default: if (!wait_req) m_phase = 0;
    endcase
    for (int i = 0; i < 16; i++) begin
      if (raw_keys[i] == m_keys[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_keys[i] = raw_keys[i]; m_run[i] = 0; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("keys",          keys,                    m_keys);
    chk("any_key",       {15'b0, any_key},        {15'b0, |m_keys});
    chk("query_pressed", {15'b0, query_pressed},  {15'b0, m_keys[query_idx]});
    chk("wait_done",     {15'b0, wait_done},      {15'b0, m_done});
    chk("wait_key",      {12'b0, wait_key},       16'(m_wkey));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for a wait_done pulse; returns whether one was seen.
  task automatic wait_for_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (wait_done) seen = 1;
    end
  endtask

  bit          seen;
  bit          any_done;
  int          hold;
  logic [15:0] bounce;

  initial begin
    for (int i = 0; i < 16; i++) m_run[i] = 0;
    rst_n = 1'b0; raw_keys = 16'hFFFF; query_idx = 4'd0; wait_req = 1'b0;

    // Reset with every raw key down.
    ticks(2);
    chk("rst_keys", keys, 16'h0000);
    chk("rst_done", {15'b0, wait_done}, 16'h0000);

    // Debounce latency: three edges quiet, visible after the fourth.
    rst_n = 1'b1; raw_keys = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("deb_early", keys, 16'h0000);
    end
    tick();
    chk("deb_edge4", keys, 16'h0020);

    // Bounce on key 5: only the final run of four ones flips it.
    raw_keys = 16'h0000;
    ticks(DEB);
    bounce = 16'b1111_0111;
    for (int i = 0; i < 8; i++) begin
      raw_keys = {10'b0, bounce[i], 5'b0};
      tick();
      chk("bounce", {15'b0, keys[5]}, {15'b0, (i == 7)});
    end

    // Query mux.
    raw_keys = 16'h8001;
    ticks(DEB + 1);
    chk("q_keys", keys, 16'h8001);
    query_idx = 4'd0;  #1; chk("q_idx0",  {15'b0, query_pressed}, 16'h0001);
    query_idx = 4'd15; #1; chk("q_idx15", {15'b0, query_pressed}, 16'h0001);
    query_idx = 4'd7;  #1; chk("q_idx7",  {15'b0, query_pressed}, 16'h0000);
    chk("q_any", {15'b0, any_key}, 16'h0001);

    // Basic FX0A: press A, release, done lands one edge after keys clears.
    raw_keys = 16'h0000;
    ticks(DEB + 1);
    wait_req = 1'b1;
    tick();
    raw_keys = 16'h0400;
    ticks(DEB + 3);
    raw_keys = 16'h0000;
    for (int i = 0; i < DEB; i++) begin
      tick();
      chk("basic_early", {15'b0, wait_done}, 16'h0000);
    end
    tick();
    chk("basic_done", {15'b0, wait_done}, 16'h0001);
    chk("basic_key",  {12'b0, wait_key},  16'h000A);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("basic_no_repeat", {15'b0, wait_done}, 16'h0000);
    end
    wait_req = 1'b0;
    tick();

    // Key 3 held at arm time; 9 and 6 pressed together, 6 wins.
    raw_keys = 16'h0008;
    ticks(DEB + 1);
    wait_req = 1'b1;
    tick();
    raw_keys = 16'h0248;
    ticks(DEB + 2);
    raw_keys = 16'h0048;
    any_done = 0;
    for (int i = 0; i < DEB + 3; i++) begin
      tick();
      if (wait_done) any_done = 1;
    end
    chk("prio_no_done_on_9", {15'b0, any_done}, 16'h0000);
    raw_keys = 16'h0008;
    wait_for_done(DEB + 4, seen);
    chk("prio_done", {15'b0, seen}, 16'h0001);
    chk("prio_key6", {12'b0, wait_key}, 16'h0006);
    wait_req = 1'b0;
    tick();

    // Key 3 released and pressed again becomes eligible.
    wait_req = 1'b1;
    tick();
    raw_keys = 16'h0000;
    ticks(DEB + 2);
    raw_keys = 16'h0008;
    ticks(DEB + 2);
    raw_keys = 16'h0000;
    wait_for_done(DEB + 4, seen);
    chk("repress_done", {15'b0, seen}, 16'h0001);
    chk("repress_key3", {12'b0, wait_key}, 16'h0003);
    wait_req = 1'b0;
    tick();

    // Abort in WAIT_RELEASE: no pulse, previous wait_key kept.
    wait_req = 1'b1;
    tick();
    raw_keys = 16'h0002;
    ticks(DEB + 2);
    wait_req = 1'b0;
    tick();
    raw_keys = 16'h0000;
    any_done = 0;
    for (int i = 0; i < DEB + 4; i++) begin
      tick();
      if (wait_done) any_done = 1;
    end
    chk("abort_no_done", {15'b0, any_done}, 16'h0000);
    chk("abort_key",     {12'b0, wait_key}, 16'h0003);

    // Reset during WAIT_PRESS.
    wait_req = 1'b1;
    tick();
    raw_keys = 16'h0010;
    ticks(2);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_keys", keys, 16'h0000);
    chk("rst_mid_wkey", {12'b0, wait_key}, 16'h0000);
    rst_n = 1'b1; wait_req = 1'b0; raw_keys = 16'h0000;
    ticks(2);

    // Randomized traffic against the model.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0: raw_keys = 16'h0000;
          1: raw_keys = 16'(1 << $urandom_range(0, 15));
          2: raw_keys = 16'($urandom) & 16'($urandom);
          default: raw_keys = raw_keys ^ 16'(1 << $urandom_range(0, 15));
        endcase
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 24) == 0) wait_req = ~wait_req;
      rst_n = ($urandom_range(0, 799) != 0);
      query_idx = 4'($urandom_range(0, 15));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on simulated time in case the main sequence stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
